// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI initiator and the co-processors it drives.
package pcpi_pkg;

    localparam logic [6:0] OPC_CUSTOM = 7'b0110011;
    localparam logic [6:0] F7_COPROC  = 7'b0000001;

    // funct3 op codes, shared with the co-processor decoder
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_TIMEOUT = 2'b01;
    localparam logic [1:0] STS_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [31:0] insn);
        return (insn[6:0] == OPC_CUSTOM) && (insn[31:25] == F7_COPROC);
    endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Counts consecutive silent responder cycles; expire_o pulses on the cycle
// that would bring the count to TIMEOUT. TIMEOUT = 0 never expires.
module pcpi_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;

    // Expiry is decided combinationally so the owner can leave ISSUE on the
    // same edge the TIMEOUT-th silent cycle is sampled.
    assign expire_o = (TIMEOUT != 0) && en_i && !clr_i && (cnt_q == LAST);

    // Silent-cycle counter; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pcpi_cmd_initiator.sv
// Initiator end of PCPI: takes one command over STB/BUSY, issues it to a
// co-processor, and returns result, status and latency over STB/BUSY.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_BUSY low
// ST_ISSUE | pico_valid high, waiting for pico_ready or timeout
// ST_RESP  | response presented, waiting for downstream to take it
module pcpi_cmd_initiator
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CYC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_input_STB,
    input  logic [31:0]      cmd_insn,
    input  logic [31:0]      cmd_rs1,
    input  logic [31:0]      cmd_rs2,
    output logic             cmd_BUSY,
    output logic             pico_valid,
    output logic [31:0]      pico_insn,
    output logic [31:0]      pico_rs1,
    output logic [31:0]      pico_rs2,
    input  logic             pico_wr,
    input  logic [31:0]      pico_rd,
    input  logic             pico_wait,
    input  logic             pico_ready,
    output logic             rsp_output_STB,
    output logic [31:0]      rsp_result,
    output logic             rsp_wr,
    output logic [1:0]       rsp_status,
    output logic [CYC_W-1:0] rsp_cycles,
    input  logic             output_module_BUSY
);

    state_e             state_q;
    logic               busy_q;
    logic               valid_q;
    logic [31:0]        insn_q;
    logic [31:0]        rs1_q;
    logic [31:0]        rs2_q;
    logic               stb_q;
    logic [31:0]        result_q;
    logic               wr_q;
    logic [1:0]         status_q;
    logic [CYC_W-1:0]   cycles_q;
    logic [CYC_W-1:0]   cycles_d;
    logic               to_clr;
    logic               to_en;
    logic               to_expire;

    // The silent-cycle count only runs inside ISSUE; pico_wait restarts it.
    assign to_clr = (state_q != ST_ISSUE) || pico_wait;
    assign to_en  = (state_q == ST_ISSUE) && !pico_wait && !pico_ready;

    pcpi_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .expire_o (to_expire)
    );

    // Saturating latency increment.
    assign cycles_d = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);

    // Command/response sequencing with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            stb_q    <= 1'b0;
            result_q <= '0;
            wr_q     <= 1'b0;
            status_q <= STS_OK;
            cycles_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_input_STB && !busy_q) begin
                        busy_q   <= 1'b1;
                        insn_q   <= cmd_insn;
                        rs1_q    <= cmd_rs1;
                        rs2_q    <= cmd_rs2;
                        cycles_q <= '0;
                        if (is_legal(cmd_insn)) begin
                            valid_q <= 1'b1;
                            state_q <= ST_ISSUE;
                        end else begin
                            status_q <= STS_ILLEGAL;
                            result_q <= '0;
                            wr_q     <= 1'b0;
                            stb_q    <= 1'b1;
                            state_q  <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    cycles_q <= cycles_d;
                    if (pico_ready) begin
                        wr_q     <= pico_wr;
                        result_q <= pico_wr ? pico_rd : 32'h0;
                        status_q <= STS_OK;
                        valid_q  <= 1'b0;
                        stb_q    <= 1'b1;
                        state_q  <= ST_RESP;
                    end else if (to_expire) begin
                        wr_q     <= 1'b0;
                        result_q <= '0;
                        status_q <= STS_TIMEOUT;
                        valid_q  <= 1'b0;
                        stb_q    <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!output_module_BUSY) begin
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_BUSY       = busy_q;
    assign pico_valid     = valid_q;
    assign pico_insn      = insn_q;
    assign pico_rs1       = rs1_q;
    assign pico_rs2       = rs2_q;
    assign rsp_output_STB = stb_q;
    assign rsp_result     = result_q;
    assign rsp_wr         = wr_q;
    assign rsp_status     = status_q;
    assign rsp_cycles     = cycles_q;

endmodule

// File: tb/tb_pcpi_cmd_initiator.sv
// Bench for pcpi_cmd_initiator: scripted and randomized responder plans
// checked against a cycle-list reference model.
module tb_pcpi_cmd_initiator;

    localparam int TO     = 16;
    localparam int PLAN_N = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_input_STB;
    logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
    logic        cmd_BUSY;
    logic        pico_valid;
    logic [31:0] pico_insn, pico_rs1, pico_rs2;
    logic        pico_wr;
    logic [31:0] pico_rd;
    logic        pico_wait, pico_ready;
    logic        rsp_output_STB;
    logic [31:0] rsp_result;
    logic        rsp_wr;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_cycles;
    logic        output_module_BUSY;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Responder plan, indexed by pico_valid cycle (0 = first valid cycle).
    logic        p_wait  [PLAN_N];
    logic        p_ready [PLAN_N];
    logic        p_wr    [PLAN_N];
    logic [31:0] p_rd    [PLAN_N];

    pcpi_cmd_initiator #(.TIMEOUT(TO), .CYC_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_input_STB      (cmd_input_STB),
        .cmd_insn           (cmd_insn),
        .cmd_rs1            (cmd_rs1),
        .cmd_rs2            (cmd_rs2),
        .cmd_BUSY           (cmd_BUSY),
        .pico_valid         (pico_valid),
        .pico_insn          (pico_insn),
        .pico_rs1           (pico_rs1),
        .pico_rs2           (pico_rs2),
        .pico_wr            (pico_wr),
        .pico_rd            (pico_rd),
        .pico_wait          (pico_wait),
        .pico_ready         (pico_ready),
        .rsp_output_STB     (rsp_output_STB),
        .rsp_result         (rsp_result),
        .rsp_wr             (rsp_wr),
        .rsp_status         (rsp_status),
        .rsp_cycles         (rsp_cycles),
        .output_module_BUSY (output_module_BUSY)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int k = 0; k < PLAN_N; k++) begin
            p_wait[k] = 1'b0; p_ready[k] = 1'b0; p_wr[k] = 1'b0; p_rd[k] = '0;
        end
    endtask

    task automatic noise_responder();
        pico_wait  = 1'($urandom);
        pico_ready = 1'($urandom);
        pico_wr    = 1'($urandom);
        pico_rd    = $urandom;
    endtask

    // Reference: walk the responder plan cycle by cycle using the rules for
    // ready, wait and the silent-cycle timeout.
    function automatic void model(input logic [31:0] insn, output logic [1:0] st,
                                  output logic [31:0] res, output logic wr, output int vc);
        int silent;
        st = 2'b11; res = '0; wr = 1'b0; vc = -1;
        if (!(insn[6:0] == 7'b0110011 && insn[31:25] == 7'b0000001)) begin
            st = 2'b10; vc = 0;
            return;
        end
        silent = 0;
        for (int k = 0; k < PLAN_N + TO; k++) begin
            logic rdy, w;
            rdy = (k < PLAN_N) ? p_ready[k] : 1'b0;
            w   = (k < PLAN_N) ? p_wait[k]  : 1'b0;
            if (rdy) begin
                st = 2'b00; wr = p_wr[k]; res = p_wr[k] ? p_rd[k] : 32'h0; vc = k + 1;
                return;
            end
            if (w) silent = 0; else silent++;
            if (silent == TO) begin
                st = 2'b01; vc = k + 1;
                return;
            end
        end
    endfunction

    // Stimulus driver (no checks): issue one command, play the plan while
    // pico_valid is high, sample the response, then take it.
    task automatic run_cmd(input logic [31:0] insn, rs1, rs2,
                           output int vcyc, output logic [1:0] st, output logic [31:0] res,
                           output logic wr, output logic [15:0] cyc, output logic stb_seen,
                           output logic busy_acc, output logic ops_ok, output logic hung,
                           output logic idle_after);
        cmd_input_STB = 1'b1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
        noise_responder();
        tick();
        busy_acc = cmd_BUSY;
        cmd_input_STB = 1'b0;
        cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
        vcyc = 0; ops_ok = 1'b1; hung = 1'b0;
        while (pico_valid && !hung) begin
            if (pico_insn !== insn || pico_rs1 !== rs1 || pico_rs2 !== rs2) ops_ok = 1'b0;
            if (vcyc < PLAN_N) begin
                pico_wait = p_wait[vcyc]; pico_ready = p_ready[vcyc];
                pico_wr = p_wr[vcyc]; pico_rd = p_rd[vcyc];
            end else begin
                pico_wait = 1'b0; pico_ready = 1'b0; pico_wr = 1'b0; pico_rd = '0;
            end
            vcyc++;
            if (vcyc > 3000) hung = 1'b1;
            tick();
        end
        noise_responder();
        stb_seen = rsp_output_STB;
        st = rsp_status; res = rsp_result; wr = rsp_wr; cyc = rsp_cycles;
        output_module_BUSY = 1'b0;
        tick();
        idle_after = !cmd_BUSY && !rsp_output_STB && !pico_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_input_STB = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        pico_wait = 1'b0; pico_ready = 1'b0; pico_wr = 1'b0; pico_rd = '0;
        output_module_BUSY = 1'b0;
        tick(); tick();
        chk_cnt++;
        if ({cmd_BUSY, pico_valid, rsp_output_STB, rsp_wr, rsp_status, rsp_cycles,
             rsp_result, pico_insn, pico_rs1, pico_rs2} !== '0)
            $display("FAIL reset_outputs: some output nonzero (busy=%b valid=%b stb=%b) required all 0",
                     cmd_BUSY, pico_valid, rsp_output_STB);
        else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    // Scenario checker shared by the scripted tests: compare observed against model.
    task automatic run_and_check(input string name, input logic [31:0] insn, rs1, rs2,
                                 input int req_vc);
        int vcyc, evc;
        logic [1:0] st, est;
        logic [31:0] res, eres;
        logic wr, ewr, stb, bacc, ok, hung, idle;
        logic [15:0] cyc;
        model(insn, est, eres, ewr, evc);
        run_cmd(insn, rs1, rs2, vcyc, st, res, wr, cyc, stb, bacc, ok, hung, idle);
        chk_cnt++;
        if (hung) $display("FAIL %s_bound: pico_valid still high after 3000 cycles, required to drop", name);
        else pass_cnt++;
        chk_cnt++;
        if (req_vc >= 0 && evc != req_vc)
            $display("FAIL %s_model: model valid cycles %0d required %0d", name, evc, req_vc);
        else pass_cnt++;
        chk_cnt++;
        if (vcyc != evc) $display("FAIL %s_valid_cycles: got %0d required %0d", name, vcyc, evc);
        else pass_cnt++;
        chk_cnt++;
        if (stb !== 1'b1 || bacc !== 1'b1)
            $display("FAIL %s_handshake: stb=%b busy_at_accept=%b required 1 1", name, stb, bacc);
        else pass_cnt++;
        chk_cnt++;
        if (st !== est) $display("FAIL %s_status: got %b required %b", name, st, est);
        else pass_cnt++;
        chk_cnt++;
        if (res !== eres || wr !== ewr)
            $display("FAIL %s_result: got %h/%b required %h/%b", name, res, wr, eres, ewr);
        else pass_cnt++;
        chk_cnt++;
        if (cyc !== 16'(evc)) $display("FAIL %s_rsp_cycles: got %0d required %0d", name, cyc, evc);
        else pass_cnt++;
        chk_cnt++;
        if (!ok || !idle)
            $display("FAIL %s_ops_idle: operands_stable=%b idle_after_take=%b required 1 1", name, ok, idle);
        else pass_cnt++;
    endtask

    task automatic test_basic_ready();
        clear_plan();
        p_ready[4] = 1'b1; p_wr[4] = 1'b1; p_rd[4] = 32'h0000_1234;
        run_and_check("basic", 32'h0200_0033, 32'h0001_0002, 32'h0003_0004, 5);
        chk_cnt++;
        if (rsp_result !== 32'h0000_1234 || rsp_status !== 2'b00)
            $display("FAIL basic_hold: result %h status %b required 00001234 00", rsp_result, rsp_status);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        clear_plan();
        p_ready[0] = 1'b1; p_wr[0] = 1'b1; p_rd[0] = 32'hFFFF_FFFF;
        run_and_check("illegal", 32'h0000_0013, $urandom, $urandom, 0);
    endtask

    task automatic test_timeout();
        clear_plan();
        run_and_check("timeout", 32'h0200_1033, $urandom, $urandom, TO);
    endtask

    task automatic test_long_wait();
        clear_plan();
        for (int k = 0; k < 300; k++) p_wait[k] = 1'b1;
        p_ready[300] = 1'b1; p_wr[300] = 1'b1; p_rd[300] = 32'hDEAD_BEEF;
        run_and_check("long_wait", 32'h0200_4033, $urandom, $urandom, 301);
    endtask

    task automatic test_back_to_back();
        clear_plan();
        p_ready[0] = 1'b1; p_wr[0] = 1'b0; p_rd[0] = 32'hABCD_0001;
        run_and_check("b2b_first", 32'h0200_2033, $urandom, $urandom, 1);
        clear_plan();
        p_ready[0] = 1'b1; p_wr[0] = 1'b1; p_rd[0] = 32'h5555_AAAA;
        run_and_check("b2b_second", 32'h0200_3033, $urandom, $urandom, 1);
    endtask

    task automatic test_backpressure();
        logic [31:0] res0;
        logic [15:0] cyc0;
        logic [1:0]  st0;
        logic        wr0;
        logic [31:0] rd;
        rd = $urandom;
        output_module_BUSY = 1'b1;
        cmd_input_STB = 1'b1; cmd_insn = 32'h0200_5033; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
        tick();
        cmd_input_STB = 1'b0;
        pico_ready = 1'b1; pico_wait = 1'b0; pico_wr = 1'b1; pico_rd = rd;
        tick();
        res0 = rsp_result; cyc0 = rsp_cycles; st0 = rsp_status; wr0 = rsp_wr;
        chk_cnt++;
        if (rsp_output_STB !== 1'b1 || res0 !== rd || cyc0 !== 16'd1 || st0 !== 2'b00 || wr0 !== 1'b1)
            $display("FAIL bp_first: stb=%b res=%h cyc=%0d st=%b wr=%b required 1 %h 1 00 1",
                     rsp_output_STB, res0, cyc0, st0, wr0, rd);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cmd_input_STB = 1'(i % 2 == 0);
            cmd_insn = 32'h0200_0033; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
            noise_responder();
            tick();
            chk_cnt++;
            if (rsp_output_STB !== 1'b1 || cmd_BUSY !== 1'b1 || pico_valid !== 1'b0 ||
                rsp_result !== res0 || rsp_cycles !== cyc0 || rsp_status !== st0 || rsp_wr !== wr0)
                $display("FAIL bp_hold_%0d: stb=%b busy=%b valid=%b res=%h required 1 1 0 %h",
                         i, rsp_output_STB, cmd_BUSY, pico_valid, rsp_result, res0);
            else pass_cnt++;
        end
        cmd_input_STB = 1'b1;
        output_module_BUSY = 1'b0;
        tick();
        cmd_input_STB = 1'b0;
        chk_cnt++;
        if (rsp_output_STB !== 1'b0 || cmd_BUSY !== 1'b0 || pico_valid !== 1'b0)
            $display("FAIL bp_take: stb=%b busy=%b valid=%b required 0 0 0",
                     rsp_output_STB, cmd_BUSY, pico_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (cmd_BUSY !== 1'b0 || pico_valid !== 1'b0)
            $display("FAIL bp_no_late_accept: busy=%b valid=%b required 0 0", cmd_BUSY, pico_valid);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        clear_plan();
        cmd_input_STB = 1'b1; cmd_insn = 32'h0200_0033; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
        pico_ready = 1'b0; pico_wait = 1'b0;
        tick();
        cmd_input_STB = 1'b0;
        tick(); tick(); tick();
        chk_cnt++;
        if (pico_valid !== 1'b1 || cmd_BUSY !== 1'b1)
            $display("FAIL areset_pre: valid=%b busy=%b required 1 1", pico_valid, cmd_BUSY);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++;
        if (pico_valid !== 1'b0 || cmd_BUSY !== 1'b0 || rsp_output_STB !== 1'b0 || rsp_cycles !== '0)
            $display("FAIL areset_async: valid=%b busy=%b stb=%b cyc=%0d required 0 0 0 0",
                     pico_valid, cmd_BUSY, rsp_output_STB, rsp_cycles);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        p_wait[0] = 1'b1; p_ready[2] = 1'b1; p_wr[2] = 1'b1; p_rd[2] = 32'h0BAD_F00D;
        run_and_check("after_reset", 32'h0200_7033, $urandom, $urandom, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] insn;
            clear_plan();
            for (int k = 0; k < 64; k++) begin
                int r;
                r = $urandom_range(0, 7);
                p_ready[k] = (r == 0);
                p_wait[k]  = (r == 1 || r == 2);
                p_wr[k]    = 1'($urandom);
                p_rd[k]    = $urandom;
            end
            if ($urandom_range(0, 3) != 0) insn = {7'b0000001, 18'($urandom), 7'b0110011};
            else insn = $urandom;
            run_and_check("random", insn, $urandom, $urandom, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ready();
        test_illegal();
        test_timeout();
        test_long_wait();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pcpi_cmd_initiator.md
# pcpi_cmd_initiator

Initiator end of the PCPI co-processor interface. It accepts one custom-instruction command at a time from a local STB/BUSY producer (test sequencer, DMA descriptor walker or soft host), drives pico_valid/insn/rs1/rs2 toward a co-processor, and captures pico_wr/pico_rd on pico_ready. It returns the result on an STB/BUSY output channel with status and a latency count. It lets co-processor ops be exercised standalone without a PicoRV32 core.

## Interface
- TIMEOUT, default 255: consecutive cycles without pico_wait/pico_ready before abort; 0 disables the timeout.
- CYC_W, default 16: width of the latency counter.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_input_STB  in  1  command valid
- cmd_insn  in  32  instruction word
- cmd_rs1  in  32  operand 1
- cmd_rs2  in  32  operand 2
- cmd_BUSY  out  1  initiator is holding a command; new commands are refused
- pico_valid  out  1  PCPI request valid
- pico_insn  out  32  registered copy of cmd_insn
- pico_rs1  out  32  registered copy of cmd_rs1
- pico_rs2  out  32  registered copy of cmd_rs2
- pico_wr  in  1  responder write-enable
- pico_rd  in  32  responder result
- pico_wait  in  1  responder requests extra time
- pico_ready  in  1  responder done
- rsp_output_STB  out  1  response valid
- rsp_result  out  32  result
- rsp_wr  out  1  captured pico_wr
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 ILLEGAL
- rsp_cycles  out  CYC_W  pico_valid-high cycle count, saturating
- output_module_BUSY  in  1  downstream cannot take the response

## Operation
- Reset value of every output is 0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - A command is accepted on an edge where cmd_input_STB=1 and cmd_BUSY=0. cmd_* is captured and cmd_BUSY is set.
  - Legal means insn[6:0]=0110011 and insn[31:25]=0000001. A legal command goes to ISSUE with pico_valid=1, rsp_cycles=0 and the timeout counter at 0.
  - An illegal command goes straight to RESP: status 10, result 0, wr 0, cycles 0. pico_valid never rises.
- ISSUE:
  - rsp_cycles increments each cycle, saturating at all-ones.
  - The timeout counter increments when pico_wait=0 and pico_ready=0, and clears when pico_wait=1.
  - If pico_ready=1: capture rsp_wr=pico_wr and rsp_result=pico_wr?pico_rd:0, set status 00, drop pico_valid, go to RESP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT: status 01, result 0, wr 0, drop pico_valid, go to RESP.
  - pico_ready and timeout on the same edge: pico_ready wins.
- RESP:
  - rsp_output_STB=1, and all rsp_* fields stay stable.
  - On an edge with output_module_BUSY=0, clear STB and cmd_BUSY and go to IDLE.
- pico_insn/rs1/rs2 stay stable while pico_valid=1. They hold their last value afterwards.
- pico_ready, pico_wait and pico_wr are ignored outside ISSUE.
- cmd_* changes after acceptance are ignored.
- Async reset: every output drops to 0 immediately and the state goes to IDLE, including mid-ISSUE.

## Timing
- Accept edge N: cmd_BUSY and pico_valid are high from N+1.
- pico_ready sampled at edge M: pico_valid is low and rsp_output_STB is high from M+1.
- rsp_cycles equals the number of cycles pico_valid was high, including the ready cycle.
- Illegal command: rsp_output_STB is high from N+1.
- Minimum legal round trip is 3 edges with ready on the first valid cycle: accept, ready, response taken. cmd_BUSY drops on the response-taken edge, so the next accept is possible one edge later.
- Timeout: pico_valid is high exactly TIMEOUT cycles when pico_wait never rises.
- The command channel is not back-to-back: at most one command is outstanding.

## Structure
- Shared package pcpi_pkg holds:
  - OPC_CUSTOM=7'b0110011 and F7_COPROC=7'b0000001
  - funct3 op codes 000..101 and 111, shared with the co-processor
  - state enum and rsp_status encodings
- Sub-module pcpi_timeout_ctr: clear, enable, expire output, parameter TIMEOUT, zero disables.

## Test plan
- insn 0x0200_0033 (funct3 000), rs1=0x0001_0002, rs2=0x0003_0004; responder readies on the 5th valid cycle with wr=1, rd=0x1234 -> status 00, result 0x0000_1234, rsp_wr 1, rsp_cycles 5.
- insn 0x0000_0013 -> pico_valid never rises; STB the cycle after accept with status 10, result 0.
- TIMEOUT=16, responder silent -> pico_valid high exactly 16 cycles; status 01, result 0, rsp_cycles 16.
- pico_wait held for 300 cycles, then ready with rd=0xDEAD_BEEF, wr=1 -> no timeout; status 00, result 0xDEAD_BEEF, rsp_cycles 301.
- output_module_BUSY held for 4 cycles during RESP, cmd_input_STB pulsed meanwhile -> STB and fields stable, cmd_BUSY stays 1, second command is not accepted until the response is taken.
- Reset asserted 3 cycles into ISSUE -> pico_valid, cmd_BUSY and STB go to 0 without a clock edge; after release a fresh command completes normally.
